// File: rtl/l1_port_hakemi_pkg.sv
// Shared widths and arbiter state encodings for the L1 data-cache port arbiter.
// Debug logic can decode the state and owner with these definitions.
package l1_port_hakemi_pkg;

   localparam int L1_ADRES_BIT = 32;
   localparam int L1_VERI_BIT  = 32;
   localparam int L1_VERI_BYTE = L1_VERI_BIT / 8;

   typedef enum logic [1:0] {
      HAKEM_BOS   = 2'd0,
      HAKEM_ISTEK = 2'd1,
      HAKEM_YANIT = 2'd2
   } hakem_durum_e;

   function automatic logic [1:0] sahip_onehot(input logic aktif, input logic sahip);
      logic [1:0] oh;
      if (!aktif) begin
         oh = 2'b00;
      end else if (sahip) begin
         oh = 2'b10;
      end else begin
         oh = 2'b01;
      end
      return oh;
   endfunction

endpackage

// File: rtl/l1_port_hakemi_if.sv
// One L1 data-cache port: valid/ready request channel plus valid/ready read-data channel.
// The master side issues requests; the slave side is the cache (or the arbiter facing a requester).
interface l1_port_hakemi_if;
   import l1_port_hakemi_pkg::*;

   logic                    istek_gecerli;
   logic [L1_ADRES_BIT-1:0] istek_adres;
   logic                    istek_onbellekleme;
   logic                    istek_yaz;
   logic [L1_VERI_BIT-1:0]  istek_veri;
   logic [L1_VERI_BYTE-1:0] istek_maske;
   logic                    istek_hazir;
   logic [L1_VERI_BIT-1:0]  veri;
   logic                    veri_gecerli;
   logic                    veri_hazir;

   modport master (
      output istek_gecerli, istek_adres, istek_onbellekleme, istek_yaz,
             istek_veri, istek_maske, veri_hazir,
      input  istek_hazir, veri, veri_gecerli
   );

   modport slave (
      input  istek_gecerli, istek_adres, istek_onbellekleme, istek_yaz,
             istek_veri, istek_maske, veri_hazir,
      output istek_hazir, veri, veri_gecerli
   );

endinterface

// File: rtl/l1_port_hakemi_hakem_rr2.sv
// Two-way grant selector: a lone requester wins; ties go to the side that did not
// win last time, or always to i0 when fixed priority is selected.
module hakem_rr2 (
   input  logic [1:0] gecerli_i,
   input  logic       son_kazanan_i,
   input  logic       sabit_i,
   output logic       kazanan_o,
   output logic       talep_var_o
);

   // Winner decode from the current request pattern
   always_comb begin
      kazanan_o   = 1'b0;
      talep_var_o = |gecerli_i;
      case (gecerli_i)
         2'b01:   kazanan_o = 1'b0;
         2'b10:   kazanan_o = 1'b1;
         2'b11:   kazanan_o = sabit_i ? 1'b0 : ~son_kazanan_i;
         default: kazanan_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/l1_port_hakemi.sv
// Shares one L1 data-cache port between the data bus unit (i0) and a secondary master (i1).
// Only one transaction is in flight; the grant is held until the write is taken or the read data is consumed.
module l1_port_hakemi
   import l1_port_hakemi_pkg::*;
#(
   parameter int ADRES_BIT     = L1_ADRES_BIT,
   parameter int VERI_BIT      = L1_VERI_BIT,
   parameter int VERI_BYTE     = L1_VERI_BYTE,
   parameter int SABIT_ONCELIK = 0
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   l1_port_hakemi_if.slave        i0,
   l1_port_hakemi_if.slave        i1,
   l1_port_hakemi_if.master       port,
   output logic [1:0]             hakem_sahip_o
);

   localparam logic SABIT_S = (SABIT_ONCELIK == 32'sd1);

   hakem_durum_e durum_q, durum_d;
   logic sahip_q, sahip_d;
   logic son_kazanan_q, son_kazanan_d;
   logic kazanan_s, talep_var_s;

   logic                 sec_gecerli_s;
   logic [ADRES_BIT-1:0] sec_adres_s;
   logic                 sec_onbellekleme_s;
   logic                 sec_yaz_s;
   logic [VERI_BIT-1:0]  sec_veri_s;
   logic [VERI_BYTE-1:0] sec_maske_s;
   logic                 sec_veri_hazir_s;

   hakem_rr2 u_hakem_rr2 (
      .gecerli_i     ({i1.istek_gecerli, i0.istek_gecerli}),
      .son_kazanan_i (son_kazanan_q),
      .sabit_i       (SABIT_S),
      .kazanan_o     (kazanan_s),
      .talep_var_o   (talep_var_s)
   );

   // Current owner's request fields and read-data readiness
   always_comb begin
      if (sahip_q) begin
         sec_gecerli_s      = i1.istek_gecerli;
         sec_adres_s        = i1.istek_adres;
         sec_onbellekleme_s = i1.istek_onbellekleme;
         sec_yaz_s          = i1.istek_yaz;
         sec_veri_s         = i1.istek_veri;
         sec_maske_s        = i1.istek_maske;
         sec_veri_hazir_s   = i1.veri_hazir;
      end else begin
         sec_gecerli_s      = i0.istek_gecerli;
         sec_adres_s        = i0.istek_adres;
         sec_onbellekleme_s = i0.istek_onbellekleme;
         sec_yaz_s          = i0.istek_yaz;
         sec_veri_s         = i0.istek_veri;
         sec_maske_s        = i0.istek_maske;
         sec_veri_hazir_s   = i0.veri_hazir;
      end
   end

   // Next-state logic and output decode; everything is idle/zero outside the owner's phase
   always_comb begin
      durum_d       = durum_q;
      sahip_d       = sahip_q;
      son_kazanan_d = son_kazanan_q;

      port.istek_gecerli      = 1'b0;
      port.istek_adres        = '0;
      port.istek_onbellekleme = 1'b0;
      port.istek_yaz          = 1'b0;
      port.istek_veri         = '0;
      port.istek_maske        = '0;
      port.veri_hazir         = 1'b0;
      i0.istek_hazir  = 1'b0;
      i0.veri         = '0;
      i0.veri_gecerli = 1'b0;
      i1.istek_hazir  = 1'b0;
      i1.veri         = '0;
      i1.veri_gecerli = 1'b0;

      case (durum_q)
         HAKEM_BOS: begin
            if (talep_var_s) begin
               sahip_d = kazanan_s;
               durum_d = HAKEM_ISTEK;
            end else begin
               durum_d = HAKEM_BOS;
            end
         end
         HAKEM_ISTEK: begin
            port.istek_gecerli      = sec_gecerli_s;
            port.istek_adres        = sec_adres_s;
            port.istek_onbellekleme = sec_onbellekleme_s;
            port.istek_yaz          = sec_yaz_s;
            port.istek_veri         = sec_veri_s;
            port.istek_maske        = sec_maske_s;
            if (sahip_q) begin
               i1.istek_hazir = port.istek_hazir;
            end else begin
               i0.istek_hazir = port.istek_hazir;
            end
            // Dropping valid before acceptance is an abort: the tie-break history is left alone
            if (!sec_gecerli_s) begin
               durum_d = HAKEM_BOS;
            end else if (port.istek_hazir) begin
               if (sec_yaz_s) begin
                  durum_d       = HAKEM_BOS;
                  son_kazanan_d = sahip_q;
               end else begin
                  durum_d = HAKEM_YANIT;
               end
            end else begin
               durum_d = HAKEM_ISTEK;
            end
         end
         HAKEM_YANIT: begin
            port.veri_hazir = sec_veri_hazir_s;
            if (sahip_q) begin
               i1.veri_gecerli = port.veri_gecerli;
               i1.veri         = port.veri;
            end else begin
               i0.veri_gecerli = port.veri_gecerli;
               i0.veri         = port.veri;
            end
            if (port.veri_gecerli && sec_veri_hazir_s) begin
               durum_d       = HAKEM_BOS;
               son_kazanan_d = sahip_q;
            end else begin
               durum_d = HAKEM_YANIT;
            end
         end
         default: begin
            durum_d = HAKEM_BOS;
         end
      endcase
   end

   // State register; i1 is recorded as last winner at reset so i0 takes the first tie
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum_q       <= HAKEM_BOS;
         sahip_q       <= 1'b0;
         son_kazanan_q <= 1'b1;
      end else begin
         durum_q       <= durum_d;
         sahip_q       <= sahip_d;
         son_kazanan_q <= son_kazanan_d;
      end
   end

   assign hakem_sahip_o = sahip_onehot(durum_q != HAKEM_BOS, sahip_q);

endmodule

// File: tb/tb_l1_port_hakemi.sv
// Scoreboard bench for l1_port_hakemi: requester drivers, an L1 port model and a monitor that
// compares every port request and every read response against queues filled from the arbitration rules.
module tb_l1_port_hakemi;

   typedef struct {
      logic [31:0] adr;
      logic        onb;
      logic        yaz;
      logic [31:0] veri;
      logic [3:0]  msk;
   } txn_t;
   typedef struct { int r; txn_t t; } exp_t;
   typedef struct { int r; logic [31:0] d; } rd_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // requester-side stimulus and observations
   logic [1:0]  rq_gec = 2'b00;
   logic [31:0] rq_adr [2];
   logic [1:0]  rq_onb = 2'b00;
   logic [1:0]  rq_yaz = 2'b00;
   logic [31:0] rq_veri [2];
   logic [3:0]  rq_msk [2];
   logic [1:0]  rq_vh = 2'b00;
   logic [1:0]  rq_hz, rq_vg;
   logic [31:0] rq_dat [2];

   // L1-side model drive
   logic        l1_hz = 1'b0;
   logic        l1_vg = 1'b0;
   logic [31:0] l1_dat = 32'h0;
   logic [1:0]  sahip;

   // fixed-priority instance stimulus
   logic [1:0]  f_gec = 2'b00;
   logic [1:0]  f_sahip;
   logic        f0_hz, f1_hz;

   int total = 0;
   int bad = 0;

   // knobs
   int  hz_mode = 1;      // 0: L1 never ready, 1: always ready, 2: random
   bit  l1_en = 1'b1;
   int  l1_dly = -1;      // -1: random latency
   bit  l1_fix = 1'b0;
   logic [31:0] l1_fixdat = 32'h0;
   bit  vh_rand = 1'b0;
   int  vh_hold = 0;
   int  exp_lat = -1;

   txn_t txq0[$], txq1[$];
   exp_t exp_q[$];
   rd_t  rd_q[$];

   l1_port_hakemi_if i0_if ();
   l1_port_hakemi_if i1_if ();
   l1_port_hakemi_if p_if ();
   l1_port_hakemi_if f0_if ();
   l1_port_hakemi_if f1_if ();
   l1_port_hakemi_if fp_if ();

   assign i0_if.istek_gecerli = rq_gec[0];
   assign i0_if.istek_adres = rq_adr[0];
   assign i0_if.istek_onbellekleme = rq_onb[0];
   assign i0_if.istek_yaz = rq_yaz[0];
   assign i0_if.istek_veri = rq_veri[0];
   assign i0_if.istek_maske = rq_msk[0];
   assign i0_if.veri_hazir = rq_vh[0];
   assign rq_hz[0] = i0_if.istek_hazir;
   assign rq_vg[0] = i0_if.veri_gecerli;
   assign rq_dat[0] = i0_if.veri;
   assign i1_if.istek_gecerli = rq_gec[1];
   assign i1_if.istek_adres = rq_adr[1];
   assign i1_if.istek_onbellekleme = rq_onb[1];
   assign i1_if.istek_yaz = rq_yaz[1];
   assign i1_if.istek_veri = rq_veri[1];
   assign i1_if.istek_maske = rq_msk[1];
   assign i1_if.veri_hazir = rq_vh[1];
   assign rq_hz[1] = i1_if.istek_hazir;
   assign rq_vg[1] = i1_if.veri_gecerli;
   assign rq_dat[1] = i1_if.veri;
   assign p_if.istek_hazir = l1_hz;
   assign p_if.veri = l1_dat;
   assign p_if.veri_gecerli = l1_vg;

   assign f0_if.istek_gecerli = f_gec[0];
   assign f0_if.istek_adres = 32'h0000_1000;
   assign f0_if.istek_onbellekleme = 1'b0;
   assign f0_if.istek_yaz = 1'b1;
   assign f0_if.istek_veri = 32'h0;
   assign f0_if.istek_maske = 4'hF;
   assign f0_if.veri_hazir = 1'b1;
   assign f0_hz = f0_if.istek_hazir;
   assign f1_if.istek_gecerli = f_gec[1];
   assign f1_if.istek_adres = 32'h0000_2000;
   assign f1_if.istek_onbellekleme = 1'b0;
   assign f1_if.istek_yaz = 1'b1;
   assign f1_if.istek_veri = 32'h0;
   assign f1_if.istek_maske = 4'hF;
   assign f1_if.veri_hazir = 1'b1;
   assign f1_hz = f1_if.istek_hazir;
   assign fp_if.istek_hazir = 1'b1;
   assign fp_if.veri = 32'h0;
   assign fp_if.veri_gecerli = 1'b0;

   l1_port_hakemi #(.SABIT_ONCELIK(0)) dut (
      .clk_i(clk), .rstn_i(rstn), .i0(i0_if), .i1(i1_if), .port(p_if), .hakem_sahip_o(sahip)
   );

   l1_port_hakemi #(.SABIT_ONCELIK(1)) dut_fix (
      .clk_i(clk), .rstn_i(rstn), .i0(f0_if), .i1(f1_if), .port(fp_if), .hakem_sahip_o(f_sahip)
   );

   function automatic logic [1:0] oh(input int r);
      return (r == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out or unexpected event", nm);
   endtask

   function automatic txn_t rnd_txn(input bit wr_only);
      txn_t t;
      t.adr = $urandom;
      t.onb = 1'($urandom);
      t.yaz = wr_only ? 1'b1 : 1'($urandom);
      t.veri = $urandom;
      t.msk = 4'($urandom);
      return t;
   endfunction

   // Expected port order: both waiting -> the side that did not win last; otherwise whoever is left
   task automatic build_exp(inout int last);
      int a = 0;
      int b = 0;
      exp_t e;
      while (a < txq0.size() || b < txq1.size()) begin
         if (a < txq0.size() && (b >= txq1.size() || last == 1)) begin
            e.r = 0; e.t = txq0[a]; a++;
         end else begin
            e.r = 1; e.t = txq1[b]; b++;
         end
         exp_q.push_back(e);
         last = e.r;
      end
   endtask

   // Called at posedge+1; presents each queued transaction and follows it to completion
   task automatic run_req(input int r, input int st);
      txn_t t;
      int n;
      bit ok;
      n = (r == 0) ? txq0.size() : txq1.size();
      if (st > 0) begin
         repeat (st) @(posedge clk);
         #1;
      end
      for (int k = 0; k < n; k++) begin
         t = (r == 0) ? txq0[k] : txq1[k];
         rq_gec[r] = 1'b1; rq_adr[r] = t.adr; rq_onb[r] = t.onb;
         rq_yaz[r] = t.yaz; rq_veri[r] = t.veri; rq_msk[r] = t.msk;
         ok = 1'b0;
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (rq_hz[r]) begin
               ok = 1'b1;
               if (exp_lat >= 0) chk("accept_latency", 64'(c), 64'(exp_lat));
               break;
            end
         end
         if (!ok) fail("accept_wait");
         @(posedge clk); #1;
         if (!t.yaz) begin
            rq_gec[r] = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 300; c++) begin
               rq_vh[r] = (c >= vh_hold) && (vh_rand ? 1'($urandom) : 1'b1);
               @(negedge clk);
               chk("owner_during_read", 64'(sahip), 64'(oh(r)));
               if (!rq_vh[r]) chk("port_veri_hazir_gated", 64'(p_if.veri_hazir), 64'd0);
               if (rq_vg[r] && rq_vh[r]) begin ok = 1'b1; break; end
               @(posedge clk); #1;
            end
            if (!ok) fail("response_wait");
            @(posedge clk); #1;
            rq_vh[r] = 1'b0;
         end
      end
      rq_gec[r] = 1'b0;
   endtask

   // L1 port model plus monitor: checks requests and responses against the scoreboard queues
   initial begin
      bit req_hs, rsp_hs, pend;
      int dly;
      logic [31:0] rdat;
      exp_t e;
      rd_t d;
      pend = 1'b0; dly = 0; rdat = 32'h0;
      forever begin
         @(negedge clk);
         req_hs = p_if.istek_gecerli & l1_hz;
         rsp_hs = l1_vg & p_if.veri_hazir;
         if (rq_hz[0] && rq_hz[1]) fail("both_hazir");
         if (l1_en && req_hs) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_request");
            end else begin
               e = exp_q.pop_front();
               chk("req_owner", 64'(sahip), 64'(oh(e.r)));
               chk("req_adres", 64'(p_if.istek_adres), 64'(e.t.adr));
               chk("req_yaz", 64'(p_if.istek_yaz), 64'(e.t.yaz));
               chk("req_veri", 64'(p_if.istek_veri), 64'(e.t.veri));
               chk("req_maske", 64'(p_if.istek_maske), 64'(e.t.msk));
               chk("req_onbellek", 64'(p_if.istek_onbellekleme), 64'(e.t.onb));
               chk("req_other_hazir", 64'(rq_hz[1-e.r]), 64'd0);
               if (!e.t.yaz) begin
                  pend = 1'b1;
                  dly = (l1_dly >= 0) ? l1_dly : int'($urandom_range(0, 4));
                  rdat = l1_fix ? l1_fixdat : 32'($urandom);
                  d.r = e.r; d.d = rdat;
                  rd_q.push_back(d);
               end
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (rq_vg[r] && rq_vh[r]) begin
               if (rd_q.size() == 0) begin
                  fail("unexpected_response");
               end else begin
                  d = rd_q.pop_front();
                  chk("rsp_requester", 64'(r), 64'(d.r));
                  chk("rsp_data", 64'(rq_dat[r]), 64'(d.d));
                  chk("rsp_other_gecerli", 64'(rq_vg[1-r]), 64'd0);
                  chk("rsp_other_data", 64'(rq_dat[1-r]), 64'd0);
               end
            end
         end
         @(posedge clk); #1;
         l1_hz = (hz_mode == 0) ? 1'b0 : (hz_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (rsp_hs) begin
            pend = 1'b0; l1_vg = 1'b0;
         end else if (pend) begin
            if (dly > 0) dly--;
            else begin l1_vg = 1'b1; l1_dat = rdat; end
         end
         if (!l1_en) begin pend = 1'b0; l1_vg = 1'b0; end
         if (!l1_vg) l1_dat = $urandom;
      end
   end

   initial begin
      #400000;
      fail("global_watchdog");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int last;
      int cnt0;
      int fr;
      int fix_q[$];
      for (int r = 0; r < 2; r++) begin
         rq_adr[r] = 32'h0; rq_veri[r] = 32'h0; rq_msk[r] = 4'h0;
      end

      // reset state
      #3;
      chk("reset_outputs", 64'({p_if.istek_gecerli, p_if.veri_hazir, rq_hz, rq_vg, sahip, f_sahip}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // i0 write, port always ready
      hz_mode = 1; exp_lat = 1;
      e.r = 0; e.t = '{32'h8000_0010, 1'b1, 1'b1, 32'hCAFE_0001, 4'b0011};
      txq0 = {e.t}; txq1 = {}; exp_q.push_back(e);
      @(posedge clk); #1;
      run_req(0, 0);
      @(negedge clk);
      chk("write_hazir_pulse", 64'({rq_hz[0], sahip}), 64'd0);

      // i1 read with fixed latency and data
      exp_lat = -1; l1_dly = 3; l1_fix = 1'b1; l1_fixdat = 32'hDEAD_BEEF;
      e.r = 1; e.t = '{32'h4000_0000, 1'b1, 1'b0, 32'h0, 4'hF};
      txq0 = {}; txq1 = {e.t}; exp_q.push_back(e);
      @(posedge clk); #1;
      run_req(1, 0);

      // i0 read stalled by its own veri_hazir; i1 must wait behind it
      l1_fix = 1'b0; l1_dly = 0; vh_hold = 5;
      txq0 = {rnd_txn(1'b0)}; txq0[0].yaz = 1'b0;
      txq1 = {rnd_txn(1'b1)};
      e.r = 0; e.t = txq0[0]; exp_q.push_back(e);
      e.r = 1; e.t = txq1[0]; exp_q.push_back(e);
      @(posedge clk); #1;
      fork
         run_req(0, 0);
         run_req(1, 2);
      join
      vh_hold = 0;

      // asynchronous reset while an i0 read is outstanding
      l1_en = 1'b0; hz_mode = 1;
      @(posedge clk); #1;
      rq_gec[0] = 1'b1; rq_yaz[0] = 1'b0; rq_adr[0] = 32'h1234_5670; rq_vh[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pre_accept", 64'(rq_hz[0]), 64'd1);
      @(posedge clk); #1;
      rq_gec[0] = 1'b0;
      @(negedge clk);
      chk("rst_pre_yanit", 64'({sahip, p_if.veri_hazir}), 64'({2'b01, 1'b1}));
      #1 rstn = 1'b0;
      #1 chk("rst_immediate", 64'({p_if.istek_gecerli, p_if.veri_hazir, rq_hz, rq_vg, sahip}), 64'd0);
      @(posedge clk); #1;
      rq_vh[0] = 1'b0; rstn = 1'b1;

      // i0 aborts an ungranted request; tie-break history must stay with i0 first
      hz_mode = 0;
      @(posedge clk); #1;
      rq_gec[0] = 1'b1;
      @(negedge clk);
      chk("abort_bos", 64'(sahip), 64'd0);
      @(negedge clk);
      chk("abort_istek", 64'({sahip, p_if.istek_gecerli, rq_hz[0]}), 64'({2'b01, 1'b1, 1'b0}));
      @(posedge clk); #1;
      rq_gec[0] = 1'b0;
      @(negedge clk);
      chk("abort_port_gecerli", 64'(p_if.istek_gecerli), 64'd0);
      @(negedge clk);
      chk("abort_idle", 64'(sahip), 64'd0);

      // round-robin rounds: 4 writes each, then random mixes with stalls
      l1_en = 1'b1; hz_mode = 2; l1_dly = -1; vh_rand = 1'b1;
      last = 1;
      for (int rnd = 0; rnd < 3; rnd++) begin
         txq0 = {}; txq1 = {};
         for (int k = 0; k < ((rnd == 0) ? 4 : int'($urandom_range(4, 8))); k++) txq0.push_back(rnd_txn(rnd == 0));
         for (int k = 0; k < ((rnd == 0) ? 4 : int'($urandom_range(4, 8))); k++) txq1.push_back(rnd_txn(rnd == 0));
         build_exp(last);
         @(posedge clk); #1;
         fork
            run_req(0, 0);
            run_req(1, 0);
         join
      end
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 64'({exp_q.size(), rd_q.size()}), 64'd0);

      // fixed priority: i0 keeps winning ties until it stops requesting
      fix_q = {0, 0, 0, 1};
      cnt0 = 0;
      @(posedge clk); #1;
      f_gec = 2'b11;
      for (int c = 0; c < 60 && fix_q.size() > 0; c++) begin
         @(negedge clk);
         if (fp_if.istek_gecerli) begin
            fr = fix_q.pop_front();
            chk("fix_owner", 64'(f_sahip), 64'(oh(fr)));
            chk("fix_adres", 64'(fp_if.istek_adres), (fr == 1) ? 64'h2000 : 64'h1000);
            if (f0_hz) cnt0++;
         end
         @(posedge clk); #1;
         if (cnt0 == 3) f_gec[0] = 1'b0;
         if (fix_q.size() == 0) f_gec = 2'b00;
      end
      if (fix_q.size() != 0) fail("fix_order_wait");

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
